// File: rtl/rr_switch_allocator_if.sv
// Switch-request / crossbar-select bundle between the input block, the
// allocator and the crossbar.
interface rr_switch_allocator_if #(
    parameter int PORT_NUM = 5,
    parameter int SEL_W    = $clog2(PORT_NUM)
);
    logic [PORT_NUM-1:0]            switch_request_i;
    logic [PORT_NUM-1:0][SEL_W-1:0] out_port_i;
    logic [PORT_NUM-1:0]            tail_i;
    logic [PORT_NUM-1:0]            on_off_i;
    logic [PORT_NUM-1:0]            valid_sel_o;
    logic [PORT_NUM-1:0][SEL_W-1:0] xb_sel_o;
    logic [PORT_NUM-1:0]            xb_valid_o;
    logic [PORT_NUM-1:0]            error_o;

    modport master (
        output switch_request_i, out_port_i, tail_i, on_off_i,
        input  valid_sel_o, xb_sel_o, xb_valid_o, error_o
    );

    modport slave (
        input  switch_request_i, out_port_i, tail_i, on_off_i,
        output valid_sel_o, xb_sel_o, xb_valid_o, error_o
    );
endinterface

// File: rtl/rr_switch_allocator.sv
// Round-robin wormhole switch allocator: one arbiter per output port, each
// holding its output for a whole packet once a head flit wins.
module rr_out_arb #(
    parameter int PORT_NUM = 5,
    parameter int SEL_W    = $clog2(PORT_NUM),
    parameter int OUT_IDX  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUM-1:0]            req,
    input  logic [PORT_NUM-1:0][SEL_W-1:0] out_port,
    input  logic [PORT_NUM-1:0]            tail,
    input  logic                           on_off,
    input  logic [PORT_NUM-1:0]            blocked,
    output logic [PORT_NUM-1:0]            gnt,
    output logic                           xb_valid,
    output logic [SEL_W-1:0]               xb_sel,
    output logic [PORT_NUM-1:0]            lock_own,
    output logic                           err
);
    typedef enum logic {IDLE, LOCKED} mode_t;

    localparam logic [SEL_W-1:0] ME   = SEL_W'(OUT_IDX);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(PORT_NUM - 1);

    mode_t             mode_q, mode_d;
    logic [SEL_W-1:0]  owner_q, owner_d, ptr_q, ptr_d, sel_q, sel_d;
    logic              err_q, err_d;
    logic [PORT_NUM-1:0] elig;
    logic              found;
    logic [SEL_W-1:0]  win, idx;
    int                c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // Eligibility and the round-robin / locked winner search.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = owner_q;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < PORT_NUM; i++)
            elig[i] = req[i] && (out_port[i] == ME) && on_off && !blocked[i];
        if (mode_q == LOCKED) begin
            found = elig[owner_q];
        end else begin
            for (int k = 0; k < PORT_NUM; k++) begin
                c   = (int'(ptr_q) + k) % PORT_NUM;
                idx = SEL_W'(c);
                if (!found && elig[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
    end

    always_comb begin
        mode_d  = mode_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        // An owner steering its packet elsewhere is a protocol violation.
        err_d   = err_q | ((mode_q == LOCKED) && req[owner_q] && (out_port[owner_q] != ME));
        if (xb_valid) begin
            sel_d = win;
            if (mode_q == IDLE) begin
                ptr_d = (win == LAST) ? '0 : win + 1'b1;
                if (!tail[win]) begin
                    mode_d  = LOCKED;
                    owner_d = win;
                end
            end else if (tail[win]) begin
                mode_d = IDLE;
            end
        end
    end

    always_comb begin
        gnt      = '0;
        xb_valid = rst && found;
        if (xb_valid)
            gnt[win] = 1'b1;
        xb_sel   = xb_valid ? win : sel_q;
        lock_own = '0;
        if (mode_q == LOCKED)
            lock_own[owner_q] = 1'b1;
        err      = err_q;
    end
endmodule

module rr_switch_allocator #(
    parameter int PORT_NUM = 5,
    parameter int SEL_W    = $clog2(PORT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_switch_allocator_if.slave  sw
);
    logic [PORT_NUM-1:0][PORT_NUM-1:0] gnt, lock_own;
    logic [PORT_NUM-1:0]               blocked, xb_valid, err, vs;
    logic [PORT_NUM-1:0][SEL_W-1:0]    xb_sel;

    // A lock owner asking for another output must not win anywhere.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int o = 0; o < PORT_NUM; o++)
                if (lock_own[o][i] && (sw.out_port_i[i] != SEL_W'(o)))
                    blocked[i] = 1'b1;
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
        rr_out_arb #(
            .PORT_NUM (PORT_NUM),
            .SEL_W    (SEL_W),
            .OUT_IDX  (o)
        ) u_arb (
            .clk      (clk),
            .rst      (rst),
            .req      (sw.switch_request_i),
            .out_port (sw.out_port_i),
            .tail     (sw.tail_i),
            .on_off   (sw.on_off_i[o]),
            .blocked  (blocked),
            .gnt      (gnt[o]),
            .xb_valid (xb_valid[o]),
            .xb_sel   (xb_sel[o]),
            .lock_own (lock_own[o]),
            .err      (err[o])
        );
    end

    always_comb begin
        vs = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int o = 0; o < PORT_NUM; o++)
                vs[i] = vs[i] | gnt[o][i];
    end

    assign sw.valid_sel_o = vs;
    assign sw.xb_valid_o  = xb_valid;
    assign sw.xb_sel_o    = xb_sel;
    assign sw.error_o     = err;
endmodule

// File: tb/tb_rr_switch_allocator.sv
// Scoreboarded bench for rr_switch_allocator: a behavioural model predicts
// each cycle's grants, plus directed checks for the key scenarios.
module tb_rr_switch_allocator;
    localparam int P = 5;
    localparam int S = $clog2(P);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rr_switch_allocator_if #(.PORT_NUM(P)) sw();
    rr_switch_allocator #(.PORT_NUM(P)) dut (.clk(clk), .rst(rst), .sw(sw));

    typedef struct {
        logic [P-1:0]        vs;
        logic [P-1:0]        xv;
        logic [P-1:0][S-1:0] xs;
        logic [P-1:0]        er;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_bad = 0;

    logic [P-1:0]        rq, tl, on;
    logic [P-1:0][S-1:0] op;
    logic [P-1:0]        obs_vs, obs_xv, obs_er;
    logic [P-1:0][S-1:0] obs_xs;

    assign sw.switch_request_i = rq;
    assign sw.out_port_i       = op;
    assign sw.tail_i           = tl;
    assign sw.on_off_i         = on;

    bit m_lk[P];
    bit m_err[P];
    int m_own[P], m_ptr[P], m_sel[P], m_win[P];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_eval(output exp_t e);
        bit blk[P];
        int c;
        e.vs = '0; e.xv = '0; e.xs = '0; e.er = '0;
        for (int i = 0; i < P; i++) begin
            blk[i] = 1'b0;
            for (int o = 0; o < P; o++)
                if (m_lk[o] && m_own[o] == i && int'(op[i]) != o) blk[i] = 1'b1;
        end
        for (int o = 0; o < P; o++) begin
            m_win[o] = -1;
            if (rst) begin
                if (m_lk[o]) begin
                    c = m_own[o];
                    if (rq[c] && int'(op[c]) == o && on[o] && !blk[c]) m_win[o] = c;
                end else begin
                    for (int k = 0; k < P; k++) begin
                        c = (m_ptr[o] + k) % P;
                        if (m_win[o] < 0 && rq[c] && int'(op[c]) == o && on[o] && !blk[c])
                            m_win[o] = c;
                    end
                end
            end
            if (m_win[o] >= 0) begin
                e.vs[m_win[o]] = 1'b1;
                e.xv[o]        = 1'b1;
                e.xs[o]        = S'(m_win[o]);
            end else begin
                e.xs[o] = S'(m_sel[o]);
            end
            e.er[o] = m_err[o];
        end
    endtask

    task automatic m_upd();
        int w;
        for (int o = 0; o < P; o++) begin
            if (!rst) begin
                m_lk[o] = 0; m_err[o] = 0; m_own[o] = 0; m_ptr[o] = 0; m_sel[o] = 0;
            end else begin
                if (m_lk[o] && rq[m_own[o]] && int'(op[m_own[o]]) != o) m_err[o] = 1;
                w = m_win[o];
                if (w >= 0) begin
                    m_sel[o] = w;
                    if (!m_lk[o]) begin
                        m_ptr[o] = (w + 1) % P;
                        if (!tl[w]) begin
                            m_lk[o]  = 1;
                            m_own[o] = w;
                        end
                    end else if (tl[w]) begin
                        m_lk[o] = 0;
                    end
                end
            end
        end
    endtask

    // One cycle: predict, push, sample mid-cycle, pop/compare, advance model.
    task automatic step();
        exp_t e, g;
        #1;
        m_eval(e);
        sbq.push_back(e);
        @(negedge clk);
        obs_vs = sw.valid_sel_o;
        obs_xv = sw.xb_valid_o;
        obs_xs = sw.xb_sel_o;
        obs_er = sw.error_o;
        if (sbq.size() == 0) begin
            chk("sbq_empty", 64'd1, 64'd0);
        end else begin
            g = sbq.pop_front();
            chk("valid_sel", obs_vs, g.vs);
            chk("xb_valid", obs_xv, g.xv);
            chk("xb_sel", obs_xs, g.xs);
            chk("error", obs_er, g.er);
        end
        m_upd();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rq = '0; tl = '0; on = '1; op = '0;
    endtask

    task automatic do_rst();
        rst = 1'b0;
        clr();
        step();
        rst = 1'b1;
    endtask

    logic [P-1:0] fv[4];
    int           fs[4];

    initial begin
        fv = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
        fs = '{0, 2, 4, 0};
        clr();
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_upd();

        // reset state: requests present but nothing granted
        rq = '1;
        step();
        chk("rst_vs", obs_vs, 0);
        chk("rst_xv", obs_xv, 0);
        chk("rst_xs", obs_xs, 0);
        chk("rst_er", obs_er, 0);

        // fairness with wrap 4 -> 0
        do_rst();
        rq = 5'b10101; op[0] = 1; op[2] = 1; op[4] = 1; tl = '1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fair_vs", obs_vs, fv[k]);
            chk("fair_xs1", obs_xs[1], fs[k]);
        end

        // packet lock
        do_rst();
        rq[3] = 1; op[3] = 0; tl[3] = 0;
        step();
        chk("lock_head", obs_vs, 5'b01000);
        rq[1] = 1; op[1] = 0; tl[1] = 1;
        for (int k = 0; k < 3; k++) begin
            tl[3] = (k == 2);
            step();
            chk("lock_body", obs_vs, 5'b01000);
        end
        rq[3] = 0;
        step();
        chk("lock_next", obs_vs, 5'b00010);

        // backpressure mid-packet
        do_rst();
        rq[2] = 1; op[2] = 2; tl[2] = 0;
        step();
        chk("bp_head", obs_vs, 5'b00100);
        rq[0] = 1; op[0] = 2; tl[0] = 1; on[2] = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_vs", obs_vs, 0);
            chk("bp_stall_xv2", obs_xv[2], 0);
        end
        on[2] = 1;
        step();
        chk("bp_resume", obs_vs, 5'b00100);
        chk("bp_xs2", obs_xs[2], 2);
        tl[2] = 1;
        step();
        chk("bp_tail", obs_vs, 5'b00100);
        rq[2] = 0;
        step();
        chk("bp_next", obs_vs, 5'b00001);

        // parallel grants
        do_rst();
        rq = 5'b00111; op[0] = 4; op[1] = 3; op[2] = 0; tl = '1;
        step();
        chk("par_vs", obs_vs, 5'b00111);
        chk("par_xv", obs_xv, 5'b11001);
        chk("par_xs4", obs_xs[4], 0);
        chk("par_xs3", obs_xs[3], 1);
        chk("par_xs0", obs_xs[0], 2);

        // owner switches output while locked
        do_rst();
        rq[3] = 1; op[3] = 1; tl[3] = 0;
        step();
        chk("err_head", obs_vs, 5'b01000);
        op[3] = 2;
        step();
        chk("err_nogrant", obs_vs, 0);
        chk("err_early", obs_er, 0);
        rq[4] = 1; op[4] = 1; tl[4] = 1;
        step();
        chk("err_stall", obs_vs, 0);
        chk("err_set", obs_er, 5'b00010);
        clr();
        step();
        chk("err_sticky", obs_er, 5'b00010);

        // reset mid-packet drops the lock and the error
        do_rst();
        step();
        chk("err_cleared", obs_er, 0);
        rq[2] = 1; op[2] = 0; tl[2] = 0;
        step();
        chk("mid_head", obs_vs, 5'b00100);
        rst = 1'b0;
        rq[0] = 1; op[0] = 0; tl[0] = 1;
        step();
        chk("mid_rst_vs", obs_vs, 0);
        chk("mid_rst_xv", obs_xv, 0);
        rst = 1'b1;
        step();
        chk("mid_after", obs_vs, 5'b00001);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_switch_allocator.md
# rr_switch_allocator

Round-robin, packet-locking switch allocator for the router's crossbar. It sits between the input block's switch-request side and the crossbar. Each cycle it grants at most one input port per output port and at most one output per input. It holds an output for a whole packet (wormhole), so body flits are never interleaved. It also drives the crossbar input-select for each output.

## Interface
- PORT_NUM, 5: number of router ports; inputs and outputs are indexed 0..PORT_NUM-1 in port_t encoding.
- SEL_W, $clog2(PORT_NUM): width of a port index.

- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- switch_request_i[PORT_NUM]  input  1  input port i has a flit ready for switch traversal.
- out_port_i[PORT_NUM]  input  port_t  output port requested by input i (valid when its request is high).
- tail_i[PORT_NUM]  input  1  the requesting flit of input i is a tail (or head-tail) flit.
- on_off_i[PORT_NUM]  input  1  downstream of output o can accept a flit (1 = on).
- valid_sel_o[PORT_NUM]  output  1  grant to input i; input pops its flit this cycle.
- xb_sel_o[PORT_NUM]  output  SEL_W  input index routed to output o.
- xb_valid_o[PORT_NUM]  output  1  output o carries a granted flit this cycle.
- error_o[PORT_NUM]  output  1  sticky protocol error on output o.

## Operation
- Per-output state: mode ∈ {IDLE, LOCKED}, owner[SEL_W], ptr[SEL_W]. Per-output sticky error bit.
- Input i is eligible for output o when all hold: switch_request_i[i], out_port_i[i]==o, on_off_i[o].
- Grants are combinational from the current inputs and registered state. State updates at the edge.

IDLE:
- Grant the first eligible input, searching from ptr, ptr+1, … mod PORT_NUM.
- No eligible input: no grant, no state change.
- On a grant to winner w: ptr ← (w+1) mod PORT_NUM.
- If tail_i[w]=0: mode ← LOCKED, owner ← w. If tail_i[w]=1 (single-flit packet): stay IDLE.

LOCKED:
- Only the owner may be granted. Other eligible inputs are stalled.
- Owner not eligible (no request, or on_off_i[o]=0): no grant, stay LOCKED.
- Owner granted with tail_i=1: mode ← IDLE. ptr is unchanged, since it already points past the owner.

Error handling:
- Owner of output o requests a different output while o is LOCKED: error_o[o] ← 1 (sticky until reset).
- That request is not granted by any output. Lock state is unchanged.

Crossbar outputs:
- xb_valid_o[o]=1 exactly when some input is granted to o.
- xb_sel_o[o] = the granted input index, else held at its last granted value.
- valid_sel_o[i] = OR over o of the grant to i. It is one-hot-or-zero per output and at most one per input by construction.

Boundary conditions:
- on_off_i[o] dropping mid-packet: output stays LOCKED and resumes when it returns to 1.
- ptr wrap: PORT_NUM-1 → 0.
- Several eligible inputs in IDLE: the strict round-robin winner from ptr is granted; the rest wait.
- Tail grant and a new request in the same cycle: the new packet can win only from the next cycle, via IDLE arbitration.

## Timing
- Grant latency 0: the request in cycle t produces valid_sel_o, xb_sel_o and xb_valid_o in cycle t.
- mode, owner, ptr and error update at the rising edge ending cycle t.
- Reset (rst=0 at an edge) sets mode=IDLE, ptr=0, owner=0, xb_sel_o=0 and error_o=0 for all outputs.
- While rst=0, valid_sel_o and xb_valid_o are forced to 0 regardless of inputs.
- Reset mid-packet drops all locks. The first cycle after reset release arbitrates from ptr=0.
- Back-to-back grants: a locked owner can be granted every cycle, giving full throughput per output.

## Test plan
- Fairness:
  - Stimulus: inputs 0, 2, 4 all request output 1 with single-flit packets (tail=1), held.
  - Required response: grants cycle through 0, 2, 4, 0, …; xb_sel_o[1] follows 0, 2, 4; ptr[1] after the 3rd grant = 0.
- Packet lock:
  - Stimulus: input 3 sends head, body, body, tail to output 0 while input 1 requests output 0 continuously.
  - Required response: input 3 is granted 4 consecutive cycles; input 1 is granted in cycle 5.
- Backpressure:
  - Stimulus: on_off_i[2]=0 for cycles 2-4 mid-packet.
  - Required response: no grants on output 2 in those cycles; LOCKED owner unchanged; the packet resumes in cycle 5 with no other input interleaved.
- Parallelism:
  - Stimulus: inputs 0→4, 1→3, 2→0 in the same cycle.
  - Required response: all three valid_sel_o=1; xb_sel_o[4]=0, [3]=1, [0]=2.
- Error:
  - Stimulus: the owner of locked output 1 switches out_port_i to 2.
  - Required response: error_o[1]=1 from the next cycle; no grant to that input; error stays 1 until rst=0.
- Reset mid-packet:
  - Stimulus: rst=0 for one edge while output 0 is LOCKED to input 2.
  - Required response: outputs 0 during reset; afterward input 0 and input 2 both requesting output 0 → input 0 wins (ptr=0).
